// File: rtl/sm2_redc_arbiter.sv
// Shared SM2 fast-reduction core (512-bit product -> residue mod p) arbitrated among NREQ requesters.
// Define SM2_REDC_RR_EN for round-robin arbitration; otherwise the lowest asserted index wins.
module sm2_redc_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*512-1:0]   req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [255:0]          rsp_data,
    output logic                  busy
);

    localparam logic [255:0] P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t         state_q, state_d;
    logic [511:0]   op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic [255:0]   res_q, res_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           win_found;
    logic [IDW-1:0] win_idx;
`ifdef SM2_REDC_RR_EN
    logic [IDW-1:0] last_gnt_q, last_gnt_d;
`endif

    // Repeatedly fold the upper half using 2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p).
    // Each fold shrinks the excess by ~31 bits; eleven folds always land below 2^256,
    // after which a single conditional subtraction fully reduces the value.
    function automatic logic [255:0] sm2_reduce(input logic [511:0] x);
        logic [513:0] acc;
        logic [513:0] hi;
        logic [255:0] lo;
        acc = {2'b00, x};
        for (int i = 0; i < 11; i++) begin
            hi  = acc >> 256;
            acc = {258'd0, acc[255:0]} + (hi << 224) + (hi << 96) + hi - (hi << 64);
        end
        lo = acc[255:0];
        if (lo >= P) begin
            lo = lo - P;
        end
        return lo;
    endfunction

    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
`ifdef SM2_REDC_RR_EN
        // First valid index strictly after the last grant, wrapping modulo NREQ.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_gnt_q) + k) % NREQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            cand = k;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        id_d      = id_q;
        res_d     = res_q;
        rsp_id_d  = rsp_id_q;
        req_ready = '0;
`ifdef SM2_REDC_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!clear && win_found) begin
                    req_ready = NREQ'(1) << win_idx;
                    op_d      = req_data[512*win_idx +: 512];
                    id_d      = win_idx;
`ifdef SM2_REDC_RR_EN
                    last_gnt_d = win_idx;
`endif
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (!clear) begin
                    res_d    = sm2_reduce(op_q);
                    rsp_id_d = id_q;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over any handshake in the same cycle.
        if (clear) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            id_q     <= '0;
            res_q    <= '0;
            rsp_id_q <= '0;
`ifdef SM2_REDC_RR_EN
            last_gnt_q <= IDW'(NREQ - 1);
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            id_q     <= id_d;
            res_q    <= res_d;
            rsp_id_q <= rsp_id_d;
`ifdef SM2_REDC_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = res_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_sm2_redc_arbiter.sv
// Directed bench for sm2_redc_arbiter with NREQ=4: reduction vectors, latency,
// backpressure, clear, reset mid-operation and grant order.
module tb_sm2_redc_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam logic [255:0] P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] R256 =
        256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clear;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*512-1:0] req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [255:0]        rsp_data;
    logic                busy;

    int total = 0;
    int bad   = 0;

    sm2_redc_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial long division: independent reference for x mod p.
    function automatic logic [255:0] ref_mod(input logic [511:0] x);
        logic [256:0] r;
        r = '0;
        for (int i = 511; i >= 0; i--) begin
            r = {r[255:0], x[i]};
            if (r >= {1'b0, P}) r = r - {1'b0, P};
        end
        return r[255:0];
    endfunction

    task automatic do_op(input int idx, input logic [511:0] opnd,
                         input logic [255:0] exp_data, input string tag);
        req_data = '0;
        req_data[512*idx +: 512] = opnd;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        #1;
        check({tag, "_gnt"}, 256'(req_ready), 256'(1 << idx));
        tick();
        req_valid = '0;
        check({tag, "_busy_calc"}, 256'(busy), 256'd1);
        check({tag, "_novalid_calc"}, 256'(rsp_valid), 256'd0);
        tick();
        check({tag, "_valid"}, 256'(rsp_valid), 256'd1);
        check({tag, "_id"}, 256'(rsp_id), 256'(idx));
        check({tag, "_data"}, rsp_data, exp_data);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_idle"}, 256'(busy), 256'd0);
    endtask

    initial begin
        logic [255:0] held;
        logic         seen;
        int           w;
        int           exp_g;

        rst_n = 1'b0; clear = 1'b0; rsp_ready = 1'b0;
        req_valid = '0; req_data = '0;
        tick(); tick();
        check("rst_ready", 256'(req_ready), 256'd0);
        check("rst_valid", 256'(rsp_valid), 256'd0);
        check("rst_id", 256'(rsp_id), 256'd0);
        check("rst_data", rsp_data, 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        rst_n = 1'b1;
        tick();

        do_op(0, 512'h1, 256'h1, "one");
        do_op(1, 512'h1 << 256, R256, "pow256");
        do_op(2, {256'h0, P}, 256'h0, "eq_p");
        do_op(3, {512{1'b1}}, ref_mod({512{1'b1}}), "ones");
        check("ones_lt_p", 256'(rsp_data < P), 256'd1);
        do_op(0, {P, P}, 256'h0, "pp");

        // Backpressure: response must stay put while rsp_ready is low.
        req_data = '0;
        req_data[512*2 +: 512] = 512'h5;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        held = rsp_data;
        check("bp_data0", held, 256'h5);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 256'(rsp_valid), 256'd1);
            check("bp_stable", rsp_data, held);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_release", 256'(busy), 256'd0);

        // Clear while idle suppresses the grant.
        req_data[512*0 +: 512] = 512'h8;
        req_valid = 4'b0001;
        clear = 1'b1;
        #1;
        check("clr_idle_ready", 256'(req_ready), 256'd0);
        tick();
        check("clr_idle_busy", 256'(busy), 256'd0);
        clear = 1'b0;
        req_valid = '0;

        // Clear during CALC discards the result.
        req_data[512*2 +: 512] = 512'h7;
        req_valid = 4'b0100;
        #1;
        check("clr_calc_gnt", 256'(req_ready), 256'b0100);
        tick();
        req_valid = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_calc_busy", 256'(busy), 256'd0);
        check("clr_calc_valid", 256'(rsp_valid), 256'd0);
        tick();
        check("clr_calc_valid2", 256'(rsp_valid), 256'd0);
        do_op(2, 512'h9, 256'h9, "after_clr");

        // Reset in the middle of an operation.
        req_data = '0;
        req_data[512*1 +: 512] = 512'h3;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 256'(busy), 256'd0);
        check("mid_rst_valid", 256'(rsp_valid), 256'd0);
        check("mid_rst_data", rsp_data, 256'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_rst_no_rsp", 256'(seen), 256'd0);

        // All requesters held valid: grant order.
        for (int i = 0; i < NREQ; i++) req_data[512*i +: 512] = 512'(i + 10);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
`ifdef SM2_REDC_RR_EN
            exp_g = n % NREQ;
`else
            exp_g = 0;
`endif
            w = 0;
            while (req_ready == '0 && w < 8) begin
                tick();
                w++;
            end
            check("order_gnt", 256'(req_ready), 256'(1 << exp_g));
            tick();
            tick();
            check("order_valid", 256'(rsp_valid), 256'd1);
            check("order_id", 256'(rsp_id), 256'(exp_g));
            check("order_data", rsp_data, 256'(exp_g + 10));
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
